// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I ALU decode with ID/EX pipeline register
module alu_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_rdata,
  input  logic [XLEN-1:0]  rs2_rdata,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_ctrl,
  output logic [XLEN-1:0]  ex_op_a,
  output logic [XLEN-1:0]  ex_op_b,
  output logic [4:0]       ex_rd_addr,
  output logic             ex_reg_write,
  output logic [31:0]      ex_pc,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0010;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state_q, state_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;

  logic            dec_legal;
  logic [3:0]      dec_ctrl;
  logic [XLEN-1:0] dec_op_a;
  logic [XLEN-1:0] dec_op_b;
  logic            dec_reg_write;
  logic            capture;

  assign opcode   = id_instr[6:0];
  assign rd       = id_instr[11:7];
  assign funct3   = id_instr[14:12];
  assign funct7   = id_instr[31:25];
  assign rs1_addr = id_instr[19:15];
  assign rs2_addr = id_instr[24:20];
  assign imm_i    = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};

  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = ALU_ADD;
    unique case (opcode)
      OPC_R: begin
        if (funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_ctrl = ALU_ADD;
            3'b111:  dec_ctrl = ALU_AND;
            3'b110:  dec_ctrl = ALU_OR;
            3'b010:  dec_ctrl = ALU_SLT;
            default: dec_legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_ctrl  = ALU_SUB;
        end
      end
      OPC_I: begin
        dec_legal = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl = ALU_ADD;
          3'b111:  dec_ctrl = ALU_AND;
          3'b110:  dec_ctrl = ALU_OR;
          3'b010:  dec_ctrl = ALU_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
    // Illegal instructions flow through as an inert ADD 0,0 so a later stage can trap.
    if (!dec_legal) dec_ctrl = ALU_ADD;
  end

  assign dec_op_a      = dec_legal ? rs1_rdata : '0;
  assign dec_op_b      = !dec_legal ? '0 : (opcode == OPC_R) ? rs2_rdata : imm_i;
  assign dec_reg_write = dec_legal && (rd != 5'd0);

  assign ex_valid = (state_q == FULL);
  assign id_ready = !rst && !stall && (!ex_valid || ex_ready);
  assign capture  = id_valid && id_ready;

  always_comb begin
    state_d = state_q;
    if (flush)                           state_d = EMPTY;
    else if (capture)                    state_d = FULL;
    else if (state_q == FULL && ex_ready) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Payload loads only on a non-flushed capture; it is don't-care while EMPTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_alu_ctrl  <= ALU_ADD;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      ex_pc        <= '0;
      ex_illegal   <= 1'b0;
    end else if (capture && !flush) begin
      ex_alu_ctrl  <= dec_ctrl;
      ex_op_a      <= dec_op_a;
      ex_op_b      <= dec_op_b;
      ex_rd_addr   <= rd;
      ex_reg_write <= dec_reg_write;
      ex_pc        <= id_pc;
      ex_illegal   <= !dec_legal;
    end
  end

  // Counts every illegal capture, even one killed by a simultaneous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_count <= '0;
    end else if (capture && !dec_legal && illegal_count != {CNT_W{1'b1}}) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Instruction-decode stage that produces the `alu_ctrl` code and both operands consumed by the RV32I execute-stage ALU, and registers them into the ID/EX pipeline register. It sits between fetch and execute. It reads operands from the external register file through combinational address/data ports. It applies a valid/ready handshake with stall and flush, and counts illegal instructions.

## Interface

Parameters:
- `XLEN`, default 32: datapath width; only 32 is supported.
- `CNT_W`, default 16: width of the illegal-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `id_valid`  in  1  fetch presents a valid instruction.
- `id_ready`  out  1  stage can accept the instruction this cycle.
- `id_instr`  in  32  instruction word.
- `id_pc`  in  32  PC of the instruction.
- `rs1_addr`, `rs2_addr`  out  5  register-file read addresses; combinational from `id_instr[19:15]` and `id_instr[24:20]`.
- `rs1_rdata`, `rs2_rdata`  in  32  register-file read data, valid in the same cycle.
- `stall`  in  1  hazard unit blocks capture.
- `flush`  in  1  kill the instruction held in ID/EX (branch redirect or exception).
- `ex_ready`  in  1  execute stage consumes the ID/EX contents.
- `ex_valid`  out  1  ID/EX holds a valid instruction.
- `ex_alu_ctrl`  out  4  ALU operation code.
- `ex_op_a`, `ex_op_b`  out  32  ALU operands.
- `ex_rd_addr`  out  5  destination register.
- `ex_reg_write`  out  1  write-back enable.
- `ex_pc`  out  32  PC of the held instruction.
- `ex_illegal`  out  1  held instruction is unsupported.
- `illegal_count`  out  CNT_W  saturating count of captured illegal instructions.

## Operation

ALU codes (fixed):
- ADD = 4'b0000
- SUB = 4'b1000
- AND = 4'b0111
- OR = 4'b0110
- SLT = 4'b0010 (signed compare)

R-type decode (opcode 7'b0110011):
- funct3 000, funct7 0000000 → ADD.
- funct3 000, funct7 0100000 → SUB.
- funct3 111 → AND.
- funct3 110 → OR.
- funct3 010 → SLT.
- AND/OR/SLT require funct7 0000000.
- Operands: `op_a = rs1_rdata`, `op_b = rs2_rdata`.

I-type decode (opcode 7'b0010011):
- funct3 000 → ADDI (ADD); 111 → ANDI (AND); 110 → ORI (OR); 010 → SLTI (SLT).
- Operands: `op_a = rs1_rdata`, `op_b = {{20{instr[31]}}, instr[31:20]}`.

Illegal instructions:
- Any other opcode, funct3 or funct7 combination is illegal.
- Result: alu_ctrl ADD, both operands 0, `reg_write = 0`, `illegal = 1`.
- The instruction still passes through with `ex_valid` set, so a later stage can trap.

Register write:
- `reg_write = 1` for legal instructions with rd ≠ 0.
- rd = x0 forces `reg_write = 0`.

ID/EX register (two states, EMPTY and FULL, tracked by `ex_valid`):
- `id_ready = !stall && (!ex_valid || ex_ready)`.
- Capture when `id_valid && id_ready`: all `ex_*` fields load and `ex_valid` becomes 1.
- Drain when `ex_valid && ex_ready` with no capture: `ex_valid` becomes 0. Data fields hold their values; they are don't-care while invalid.
- Hold when `ex_valid && !ex_ready`: all fields are stable.
- Simultaneous drain and capture: the new instruction replaces the old one; `ex_valid` stays 1.
- `flush` has priority over capture and hold. The next cycle has `ex_valid = 0`, and the incoming instruction is discarded. `id_ready` is not gated by `flush`; fetch is expected to kill its own instruction.

Illegal counter:
- `illegal_count` increments by 1 on each capture whose decode is illegal, including a capture discarded by a simultaneous flush.
- It saturates at all-ones.

## Timing

- Reset values: all `ex_*` fields 0 (`ex_valid = 0`, `ex_alu_ctrl = 4'b0000`, operands, pc, rd 0) and `illegal_count = 0`.
- `rst` overrides `flush`, `stall` and capture.
- `id_ready` is 0 during reset and combinational from the current state otherwise.
- Latency: an instruction accepted at edge N is visible on `ex_*` after edge N (one cycle). Throughput is one instruction per cycle when `ex_ready` stays 1.
- `rs1_addr` and `rs2_addr` have zero latency. Register-file data is sampled at the same edge as the capture.
- `stall` with `ex_ready = 1` drains ID/EX, leaving a bubble (`ex_valid` = 0 next cycle).
- Reset in the middle of a hold drops the held instruction.

## Test plan

- **Single ADD.** Reset, then `id_instr = 0x002081B3` (ADD x3,x1,x2), rs1_rdata 5, rs2_rdata 7, `ex_ready = 1`. Next cycle: `ex_valid = 1`, alu_ctrl 0000, op_a 5, op_b 7, rd 3, reg_write 1.
- **SUB, then ADDI back to back.** `0x407302B3` (SUB x5,x6,x7) followed by `0xFFF00093` (ADDI x1,x0,-1). Consecutive cycles show alu_ctrl 1000, then alu_ctrl 0000 with op_b 0xFFFFFFFF and rd 1.
- **Backpressure.** `ex_ready = 0` for 3 cycles while `id_valid = 1`. `id_ready = 0` and `ex_*` hold stable. When `ex_ready` rises, the next instruction is captured in that same cycle.
- **Flush priority.** `flush = 1` together with a valid capture. Next cycle `ex_valid = 0`; the following instruction is captured normally.
- **Illegal instruction and counter.** `0x00000000` is captured with `ex_illegal = 1`, reg_write 0, and `illegal_count` goes 0→1. Forcing 65536 illegal captures saturates the count at 0xFFFF.
- **x0 destination and stall bubble.** ADDI x0,x1,4 gives `reg_write = 0`. `stall = 1` with `ex_ready = 1` gives `id_ready = 0` and `ex_valid` = 0 on the next cycle.
